// File: rtl/flash_step_gen_if.sv
// Control-panel bundle between the raw operator inputs and the step generator:
// raw switch/buttons in, step strobe and status levels out.
interface flash_step_gen_if;
  logic       sw_dir;
  logic       btn_speed;
  logic       btn_pause;
  logic       step;
  logic       dir;
  logic [1:0] speed_sel;
  logic       paused;

  // Level-only bundle, no valid/ready handshake: the raw inputs may change at
  // any time and step is a self-timed one-cycle strobe.
  modport master (
    output sw_dir, btn_speed, btn_pause,
    input  step, dir, speed_sel, paused
  );

  modport slave (
    input  sw_dir, btn_speed, btn_pause,
    output step, dir, speed_sel, paused
  );
endinterface

// File: rtl/flash_step_gen.sv
// Debounces the direction switch and speed/pause buttons, then generates the
// selectable-rate, pausable step strobe plus direction level for the LED chain.
module flash_step_gen #(
  parameter int BASE_DIV   = 3500,
  parameter int STEP_TICKS = 3500,
  parameter int DB_CYCLES  = 20000,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  flash_step_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(BASE_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICKS0   = CNT_W'(STEP_TICKS);

  // Bit index of every per-input vector: 0 = sw_dir, 1 = btn_speed, 2 = btn_pause
  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            db_q, db_d, db_prev_q;
  logic [2:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

  logic [CNT_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] limit;
  logic [1:0]       speed_q, speed_d;
  logic             paused_q, paused_d;
  logic             step_q, step_d;
  logic             tick, speed_hit, pause_hit;

  assign raw = {bus.btn_pause, bus.btn_speed, bus.sw_dir};

  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i]     = ~db_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + ONE;
      end
    end
  end

  // Actions fire one cycle after the debounced level rises; release is ignored.
  assign speed_hit = db_q[1] & ~db_prev_q[1];
  assign pause_hit = db_q[2] & ~db_prev_q[2];

  always_comb begin
    limit = TICKS0 >> speed_q;
    if (limit == '0) limit = ONE;
  end

  assign tick = ~paused_q & (pre_q == PRE_LAST);

  always_comb begin
    pre_d      = pre_q;
    step_cnt_d = step_cnt_q;
    step_d     = 1'b0;
    speed_d    = speed_q + {1'b0, speed_hit};
    paused_d   = paused_q ^ pause_hit;

    if (!paused_q) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + ONE;
    end

    // A speed change restarts the step wait so the new rate applies at once.
    if (speed_hit) begin
      step_cnt_d = '0;
    end else if (tick) begin
      if (step_cnt_q == limit - ONE) begin
        step_cnt_d = '0;
        step_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      db_cnt_q   <= '0;
      pre_q      <= '0;
      step_cnt_q <= '0;
      speed_q    <= '0;
      paused_q   <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      db_cnt_q   <= db_cnt_d;
      pre_q      <= pre_d;
      step_cnt_q <= step_cnt_d;
      speed_q    <= speed_d;
      paused_q   <= paused_d;
      step_q     <= step_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.dir       = db_q[0];
  assign bus.speed_sel = speed_q;
  assign bus.paused    = paused_q;
endmodule

// File: tb/tb_flash_step_gen.sv
// Bench for flash_step_gen: directed scenarios plus random input activity,
// checked against an input-history reference model feeding a step scoreboard.
module tb_flash_step_gen;
  localparam int BASE_DIV   = 4;
  localparam int STEP_TICKS = 8;
  localparam int DB_CYCLES  = 3;
  localparam int CNT_W      = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  flash_step_gen_if bus();

  flash_step_gen #(
    .BASE_DIV(BASE_DIV), .STEP_TICKS(STEP_TICKS),
    .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  // ---------------- reference model
  typedef struct packed {
    logic [2:0]      h1, h2;      // raw inputs sampled one and two edges ago
    logic [2:0]      db, db_old;  // accepted levels now and one edge ago
    logic [2:0][7:0] run;         // consecutive edges the delayed input disagreed
    logic [1:0]      speed;
    logic            paused;
    logic [31:0]     act;         // unpaused edges since reset
    logic [31:0]     ticks;       // ticks since last step or speed change
    logic [31:0]     cyc;         // edges since reset release
    logic            step;
  } mdl_t;

  mdl_t m, nxt;

  function automatic logic [31:0] lim(input logic [1:0] s);
    int l;
    l = STEP_TICKS >> s;
    return (l == 0) ? 32'd1 : 32'(l);
  endfunction

  function automatic mdl_t mdl_next(input mdl_t s, input logic [2:0] raw);
    mdl_t n;
    n        = s;
    n.step   = 1'b0;
    n.cyc    = s.cyc + 32'd1;
    n.db_old = s.db;
    n.h1     = raw;
    n.h2     = s.h1;
    for (int i = 0; i < 3; i++) begin
      if (s.h2[i] != s.db[i]) begin
        if (int'(s.run[i]) + 1 == DB_CYCLES) begin
          n.db[i]  = ~s.db[i];
          n.run[i] = 8'd0;
        end else begin
          n.run[i] = s.run[i] + 8'd1;
        end
      end else begin
        n.run[i] = 8'd0;
      end
    end
    if (!s.paused) begin
      n.act = s.act + 32'd1;
      if (n.act % BASE_DIV == 0) begin
        n.ticks = s.ticks + 32'd1;
        if (n.ticks == lim(s.speed)) begin
          n.ticks = 32'd0;
          n.step  = 1'b1;
        end
      end
    end
    if (s.db[1] && !s.db_old[1]) begin
      n.speed = s.speed + 2'd1;
      n.ticks = 32'd0;
      n.step  = 1'b0;
    end
    if (s.db[2] && !s.db_old[2]) n.paused = ~s.paused;
    return n;
  endfunction

  always_comb nxt = mdl_next(m, {bus.btn_pause, bus.btn_speed, bus.sw_dir});

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      exp_q.delete();
    end else begin
      m <= nxt;
      if (nxt.step) exp_q.push_back(nxt.cyc);
    end
  end

  // ---------------- monitor / scoreboard
  always @(negedge clk) begin
    vectors++;
    if (bus.dir !== m.db[0] || bus.speed_sel !== m.speed || bus.paused !== m.paused) begin
      errors++;
      $display("FAIL levels cyc=%0d dir/speed/paused got %b/%0d/%b expected %b/%0d/%b",
               m.cyc, bus.dir, bus.speed_sel, bus.paused, m.db[0], m.speed, m.paused);
    end
    if (bus.step === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected at cyc=%0d, expected no step", m.cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != m.cyc) begin
          errors++;
          $display("FAIL step_time got cyc=%0d expected cyc=%0d", m.cyc, mon_e);
        end
      end
    end else if (bus.step !== 1'b0) begin
      vectors++;
      errors++;
      $display("FAIL step_x got %b expected 0/1", bus.step);
    end else if (exp_q.size() > 0 && exp_q[0] <= m.cyc) begin
      vectors++;
      errors++;
      mon_e = exp_q.pop_front();
      $display("FAIL step_missing got none expected step at cyc=%0d", mon_e);
    end
  end

  // ---------------- driver tasks
  task automatic check(input string name, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_step(input int budget, output int c);
    int i;
    c = -1;
    i = 0;
    while (c < 0 && i < budget) begin
      @(negedge clk);
      i++;
      if (bus.step === 1'b1) c = int'(m.cyc);
    end
    if (c < 0) begin
      vectors++;
      errors++;
      $display("FAIL step_timeout got no step expected one within %0d cycles", budget);
    end
  endtask

  // which: bit0 = speed button, bit1 = pause button; c = cycle the action lands
  task automatic press(input int which, output int c);
    logic [1:0] s0;
    logic       p0;
    s0 = bus.speed_sel;
    p0 = bus.paused;
    if (which[0]) bus.btn_speed = 1'b1;
    if (which[1]) bus.btn_pause = 1'b1;
    c = -1;
    for (int i = 0; i < 30 && c < 0; i++) begin
      @(negedge clk);
      if (bus.speed_sel != s0 || bus.paused != p0) c = int'(m.cyc);
    end
    bus.btn_speed = 1'b0;
    bus.btn_pause = 1'b0;
    if (c < 0) begin
      vectors++;
      errors++;
      $display("FAIL press_timeout got no action expected one within 30 cycles");
    end
  endtask

  // ---------------- stimulus
  int periods[4] = '{16, 8, 4, 32};

  initial begin
    int c0, c1, c2, cs, cp, cr, cn, n, s0, p0;
    int rl[3];
    bus.sw_dir    = 1'b0;
    bus.btn_speed = 1'b0;
    bus.btn_pause = 1'b0;
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // free-running steps from reset
    wait_step(40, c0); check("first_step", c0, 32);
    wait_step(40, c1); check("second_step", c1, 64);
    wait_step(40, c2); check("third_step", c2, 96);
    check("reset_speed", int'(bus.speed_sel), 0);
    check("reset_paused", int'(bus.paused), 0);

    // direction latency and glitch rejection
    bus.sw_dir = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.dir !== 1'b1 && n < 20);
    check("dir_latency", n, 5);
    idle(4);
    bus.sw_dir = 1'b0;
    idle(2);
    bus.sw_dir = 1'b1;
    idle(10);
    check("dir_glitch", int'(bus.dir), 1);

    // speed walk 1,2,3,0
    for (int k = 0; k < 4; k++) begin
      press(1, c0);
      check("speed_value", int'(bus.speed_sel), (k + 1) % 4);
      wait_step(40, c1);
      check("speed_first_step_in_time", int'(c1 - c0 <= periods[k]), 1);
      wait_step(40, c2);
      check("speed_period", c2 - c1, periods[k]);
      idle(6);
    end

    // pause holds both counters
    wait_step(40, cs);
    idle($urandom_range(3, 10));
    press(2, cp);
    check("pause_on", int'(bus.paused), 1);
    n = 0;
    repeat ($urandom_range(10, 30)) begin
      @(negedge clk);
      if (bus.step === 1'b1) n++;
    end
    check("steps_while_paused", n, 0);
    press(2, cr);
    check("pause_off", int'(bus.paused), 0);
    wait_step(40, cn);
    check("active_time_across_pause", (cp - cs) + (cn - cr), 32);

    // simultaneous speed and pause edges
    idle(8);
    s0 = int'(bus.speed_sel);
    p0 = int'(bus.paused);
    press(3, c0);
    check("both_speed", int'(bus.speed_sel), (s0 + 1) % 4);
    check("both_paused", int'(bus.paused), 1 - p0);

    // bouncy speed button
    idle(8);
    s0 = int'(bus.speed_sel);
    for (int i = 0; i < 10; i++) begin
      bus.btn_speed = (i % 2 == 0);
      @(negedge clk);
    end
    bus.btn_speed = 1'b1;
    idle(10);
    bus.btn_speed = 1'b0;
    idle(15);
    check("bounce_single_increment", int'(bus.speed_sel), (s0 + 1) % 4);

    // reset mid-operation at speed 2 while paused
    check("pre_reset_speed", int'(bus.speed_sel), 2);
    check("pre_reset_paused", int'(bus.paused), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_step", int'(bus.step), 0);
    check("rst_dir", int'(bus.dir), 0);
    check("rst_speed", int'(bus.speed_sel), 0);
    check("rst_paused", int'(bus.paused), 0);
    idle(2);
    rst = 1'b0;
    wait_step(40, c0);
    check("step_after_reset", c0, 32);

    // random activity on all three inputs
    rl = '{0, 0, 0};
    repeat (1500) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rl[k] == 0) begin
          rl[k] = $urandom_range(1, 12);
          case (k)
            0:       bus.sw_dir    = 1'($urandom_range(0, 1));
            1:       bus.btn_speed = 1'($urandom_range(0, 1));
            default: bus.btn_pause = 1'($urandom_range(0, 1));
          endcase
        end else begin
          rl[k]--;
        end
      end
    end
    bus.sw_dir    = 1'b0;
    bus.btn_speed = 1'b0;
    bus.btn_pause = 1'b0;
    idle(60);
    check("pending_steps", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
